// File: rtl/lock_servo_driver.sv
// Servo pulse generator for the lock actuator: one pulse per frame whose width
// slews by at most STEP per frame toward the open or closed position.
module lock_servo_driver #(
    parameter int FRAME_CLKS   = 1_000_000,
    parameter int PULSE_CLOSED = 50_000,
    parameter int PULSE_OPEN   = 100_000,
    parameter int STEP         = 5_000
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    output logic servo_pwm,
    output logic busy,
    output logic at_open,
    output logic at_closed
);

    localparam logic [19:0] FRAME_LAST = 20'(FRAME_CLKS - 1);
    localparam logic [19:0] W_CLOSED   = 20'(PULSE_CLOSED);
    localparam logic [19:0] W_OPEN     = 20'(PULSE_OPEN);
    localparam logic [19:0] STEP_W     = 20'(STEP);

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

    state_t      state_q, state_d;
    logic [19:0] frame_cnt_q, frame_cnt_d;
    logic [19:0] width_q, width_d;
    logic        pwm_q, pwm_d;
    logic        boundary;

    assign boundary = (frame_cnt_q == FRAME_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLOSED;
            frame_cnt_q <= '0;
            width_q     <= W_CLOSED;
            pwm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            width_q     <= width_d;
            pwm_q       <= pwm_d;
        end
    end

    // Saturation compares the remaining distance against STEP, so the sum or
    // difference never overshoots the end stop even when STEP doesn't divide it.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        frame_cnt_d = boundary ? '0 : frame_cnt_q + 20'd1;
        pwm_d       = (frame_cnt_q < width_q);
        if (boundary) begin
            if (lock_open) begin
                if (width_q < W_OPEN) begin
                    width_d = ((W_OPEN - width_q) > STEP_W) ? width_q + STEP_W : W_OPEN;
                    state_d = (width_d == W_OPEN) ? OPEN : OPENING;
                end else begin
                    state_d = OPEN;
                end
            end else begin
                if (width_q > W_CLOSED) begin
                    width_d = ((width_q - W_CLOSED) > STEP_W) ? width_q - STEP_W : W_CLOSED;
                    state_d = (width_d == W_CLOSED) ? CLOSED : CLOSING;
                end else begin
                    state_d = CLOSED;
                end
            end
        end
    end

    assign servo_pwm = pwm_q;
    assign busy      = (state_q == OPENING) || (state_q == CLOSING);
    assign at_open   = (state_q == OPEN);
    assign at_closed = (state_q == CLOSED);

endmodule
